// File: rtl/lcd_st7789v3_pkg.sv
// Shared definitions for the ST7789V3 LCD path: SPI serializer state
// encoding, D/C select levels used by the driver FSM, and default timing.
package lcd_st7789v3_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOW,
    ST_HIGH,
    ST_TAIL,
    ST_GAP
  } spi_tx_state_t;

  localparam logic RS_CMD  = 1'b0;
  localparam logic RS_DATA = 1'b1;

  localparam int unsigned DEF_CLK_DIV = 2;
  localparam int unsigned DEF_CS_GAP  = 2;

endpackage

// File: rtl/lcd_spi_tx_if.sv
// Byte handshake between the LCD driver FSM (master) and the SPI
// serializer (slave). A byte moves when tx_valid && tx_ready at posedge.
interface lcd_spi_tx_if;

  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_data;
  logic       tx_rs;

  modport master (output tx_valid, output tx_data, output tx_rs, input tx_ready);
  modport slave  (input tx_valid, input tx_data, input tx_rs, output tx_ready);

endinterface

// File: rtl/lcd_spi_tick.sv
// Loadable down-counter. Loading sets the count to LOAD_VAL; o_phase_done
// is high for the single cycle in which the count reads 1, i.e. the last
// cycle of a LOAD_VAL-cycle phase.
module lcd_spi_tick #(
  parameter int unsigned LOAD_VAL = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic i_load,
  output logic o_phase_done
);

  localparam int unsigned W = $clog2(LOAD_VAL + 1);

  logic [W-1:0] r_cnt;

  // Reload on request, otherwise count down and park at zero.
  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; the reset branch is asynchronous on rst low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= W'(LOAD_VAL);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_phase_done = (r_cnt == W'(1));

endmodule

// File: rtl/lcd_spi_tx.sv
// Byte-wide 4-wire SPI write serializer for the ST7789V3 panel (mode 0,
// MSB first). Each byte is framed by lcd_cs; lcd_rs carries D/C.
// All outputs are registered from the next-state value.
// Optional: define LCD_SPI_CS_BURST_EN to let a byte offered during TAIL
// follow immediately with lcd_cs held low.
module lcd_spi_tx
  import lcd_st7789v3_pkg::*;
#(
  parameter int unsigned CLK_DIV = DEF_CLK_DIV,
  parameter int unsigned CS_GAP  = DEF_CS_GAP
) (
  input  logic         clk,
  input  logic         rst,
  lcd_spi_tx_if.slave  bus,
  output logic         o_busy,
  output logic         o_lcd_cs,
  output logic         o_lcd_scl,
  output logic         o_lcd_sd,
  output logic         o_lcd_rs
);

  spi_tx_state_t r_state;
  spi_tx_state_t w_state_next;

  logic [7:0] r_data;
  logic [2:0] r_bit;
  logic       r_sd;
  logic       r_rs;
  logic       r_cs;
  logic       r_scl;
  logic       r_busy;
  logic       r_tx_ready;

  logic w_accept;
  logic w_bit_step;
  logic w_div_load;
  logic w_gap_load;
  logic w_div_done;
  logic w_gap_done;
  logic w_ready_next;

  // SCL half-period timer, reloaded at every LOW/HIGH phase entry.
  lcd_spi_tick #(.LOAD_VAL(CLK_DIV)) u_div_tick (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_div_load),
    .o_phase_done (w_div_done)
  );

  // Inter-byte CS-high timer, loaded on GAP entry.
  lcd_spi_tick #(.LOAD_VAL(CS_GAP)) u_gap_tick (
    .clk          (clk),
    .rst          (rst),
    .i_load       (w_gap_load),
    .o_phase_done (w_gap_done)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode, handshake acceptance and timer load strobes.
  // NOTE: every signal gets a default before the case so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_bit_step   = 1'b0;
    w_div_load   = 1'b0;
    w_gap_load   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (bus.tx_valid) begin
          w_accept     = 1'b1;
          w_div_load   = 1'b1;
          w_state_next = ST_LOW;
        end
      end
      ST_LOW: begin
        if (w_div_done) begin
          w_div_load   = 1'b1;
          w_state_next = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (w_div_done) begin
          if (r_bit == 3'd0) begin
            w_state_next = ST_TAIL;
          end else begin
            w_bit_step   = 1'b1;
            w_div_load   = 1'b1;
            w_state_next = ST_LOW;
          end
        end
      end
      ST_TAIL: begin
`ifdef LCD_SPI_CS_BURST_EN
        if (bus.tx_valid) begin
          w_accept     = 1'b1;
          w_div_load   = 1'b1;
          w_state_next = ST_LOW;
        end else begin
          w_gap_load   = 1'b1;
          w_state_next = ST_GAP;
        end
`else
        w_gap_load   = 1'b1;
        w_state_next = ST_GAP;
`endif
      end
      ST_GAP: begin
        if (w_gap_done) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Ready is offered in IDLE, and in TAIL only when bursting is built in.
`ifdef LCD_SPI_CS_BURST_EN
  assign w_ready_next = (w_state_next == ST_IDLE) || (w_state_next == ST_TAIL);
`else
  assign w_ready_next = (w_state_next == ST_IDLE);
`endif

  // Registered outputs and shift datapath; sd/rs move only on accept or
  // on a HIGH-to-LOW bit step, and hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_data     <= 8'h00;
      r_bit      <= 3'd0;
      r_sd       <= 1'b0;
      r_rs       <= RS_DATA;
      r_cs       <= 1'b1;
      r_scl      <= 1'b0;
      r_busy     <= 1'b0;
      r_tx_ready <= 1'b1;
    end else begin
      r_cs       <= !((w_state_next == ST_LOW) || (w_state_next == ST_HIGH) ||
                      (w_state_next == ST_TAIL));
      r_scl      <= (w_state_next == ST_HIGH);
      r_busy     <= (w_state_next != ST_IDLE);
      r_tx_ready <= w_ready_next;
      if (w_accept) begin
        r_data <= bus.tx_data;
        r_rs   <= bus.tx_rs;
        r_sd   <= bus.tx_data[7];
        r_bit  <= 3'd7;
      end else if (w_bit_step) begin
        r_bit  <= r_bit - 3'd1;
        r_sd   <= r_data[r_bit - 3'd1];
      end
    end
  end

  assign bus.tx_ready = r_tx_ready;
  assign o_busy       = r_busy;
  assign o_lcd_cs     = r_cs;
  assign o_lcd_scl    = r_scl;
  assign o_lcd_sd     = r_sd;
  assign o_lcd_rs     = r_rs;

endmodule

// File: doc/lcd_spi_tx.md
# lcd_spi_tx

Byte-wide 4-wire SPI write serializer for the ST7789V3 panel, directly downstream of the LCD driver FSM. Accepts one command or data byte at a time over a valid/ready handshake and shifts it out MSB-first on `lcd_sd` and `lcd_scl`. It frames each byte with `lcd_cs` and presents the D/C level on `lcd_rs`. The driver's init-sequence and memory-write logic push bytes into this block. It does not drive the panel pins itself.

## Interface
- `CLK_DIV`, default 2: `clk` cycles per SCL half-period; legal range ≥1. At 13.5 MHz, SCL runs at 3.375 MHz.
- `CS_GAP`, default 2: `clk` cycles with `lcd_cs` high between framed bytes; legal range ≥1.
- `clk` in 1: sole clock; all logic on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `tx_valid` in 1: byte offered.
- `tx_ready` out 1: block can accept; transfer occurs when `tx_valid && tx_ready` at a posedge.
- `tx_data` in 8: byte to send, MSB first.
- `tx_rs` in 1: 0 = command, 1 = data.
- `busy` out 1: high whenever the state is not IDLE.
- `lcd_cs` out 1: panel chip select, active low.
- `lcd_scl` out 1: SPI clock; idles low (mode 0).
- `lcd_sd` out 1: serial data.
- `lcd_rs` out 1: D/C select.

## Operation
- **States:** IDLE, LOW, HIGH, TAIL, GAP. `tx_data` and `tx_rs` are latched at acceptance; later input changes are ignored.
- **IDLE:** `tx_ready` = 1, `lcd_cs` = 1, `lcd_scl` = 0. On handshake, go to LOW with bit index 7.
- **LOW** (`CLK_DIV` cycles):
  - `lcd_cs` = 0, `lcd_scl` = 0.
  - `lcd_sd` = the current bit; `lcd_rs` = the latched RS.
  - Then go to HIGH.
- **HIGH** (`CLK_DIV` cycles):
  - `lcd_scl` = 1; `lcd_sd` is stable, and the panel samples on the rising edge.
  - Then, if the bit index is 0, go to TAIL; otherwise decrement the index and go to LOW.
- **TAIL** (1 cycle): `lcd_cs` = 0, `lcd_scl` = 0, providing CS hold time. Next state is GAP, unless the Configuration section applies.
- **GAP** (`CS_GAP` cycles): `lcd_cs` = 1, `tx_ready` = 0. Then go to IDLE.
- **Counters:** the divider counter is `$clog2(CLK_DIV+1)` bits and reloads at every phase change. The bit counter is 3 bits and never wraps past 0.
- **Output hold:** `lcd_rs` and `lcd_sd` keep their last values through TAIL, GAP and IDLE; they change only at the next acceptance.
- **Reset values:** `lcd_cs` = 1, `lcd_scl` = 0, `lcd_sd` = 0, `lcd_rs` = 1, `busy` = 0, `tx_ready` = 1. State is IDLE.
- **Reset mid-byte:** all outputs return to reset values asynchronously. The in-flight byte is discarded, and no partial SCL pulse follows.

## Timing
- All outputs are registered, with no combinational path from input to output.
- **Acceptance edge = cycle 0.** From cycle 1, `lcd_cs` is low and `lcd_sd`/`lcd_rs` are valid.
- **First SCL rise:** cycle 1+`CLK_DIV`. Rise k (k = 0..7) occurs at cycle 1+(2k+1)·`CLK_DIV`.
- **`lcd_cs` low duration per byte:** 16·`CLK_DIV`+1 cycles.
- **Accept-to-accept throughput (non-burst):** 16·`CLK_DIV`+2+`CS_GAP` cycles.
- **Data setup:** `lcd_sd` changes only on the LOW-phase entry edge, giving ≥`CLK_DIV` cycles of setup and hold around each rise.
- **`tx_valid` without `tx_ready`:** ignored, with no state change. `tx_valid` may drop without being accepted.

## Configuration
- **`LCD_SPI_CS_BURST_EN` defined:**
  - TAIL asserts `tx_ready` = 1.
  - A handshake in TAIL goes straight to LOW (bit 7) with `lcd_cs` held low, and latches the new byte and RS.
  - `lcd_rs` may change on that edge while `lcd_scl` is low.
  - Burst throughput is 16·`CLK_DIV`+1 cycles per byte.
  - With no handshake in TAIL, proceed to GAP as normal.
- **Undefined:** TAIL holds `tx_ready` = 0, and every byte is individually framed by a CS rise.

## Structure
- **Package `lcd_st7789v3_pkg`** holds:
  - the `spi_tx_state_t` enum;
  - the `RS_CMD`=1'b0 and `RS_DATA`=1'b1 constants, shared with the driver FSM;
  - the default `CLK_DIV`/`CS_GAP` constants.
- **Sub-module `lcd_spi_tick`:** a natural split. It is a loadable down-counter emitting a one-cycle `phase_done` pulse; shift, state and outputs stay in `lcd_spi_tx`.

## Test plan
All scenarios use `CLK_DIV`=2 and `CS_GAP`=2.
- **Post-reset idle:** release reset and idle 10 cycles → `lcd_cs`=1, `lcd_scl`=0, `lcd_sd`=0, `lcd_rs`=1, `tx_ready`=1, `busy`=0.
- **Single command byte:** send 0x2A with `tx_rs`=0 → `lcd_rs`=0, `lcd_cs` low for exactly 33 cycles, 8 SCL rises sampling 0,0,1,0,1,0,1,0, and the first rise 3 cycles after acceptance.
- **Back-to-back non-burst:** 0xFF (data) held valid, followed by 0x00 → acceptances 36 cycles apart, `lcd_cs` high for exactly 2 cycles between bytes.
- **Burst (`LCD_SPI_CS_BURST_EN`):** 0x36 (cmd) then 0x70 (data) with `tx_valid` held → `lcd_cs` never rises, 16 rises sampling 0x36 then 0x70, `lcd_rs` 0→1 while SCL is low, 33-cycle spacing.
- **Input stability:** change `tx_data` and `tx_rs` every cycle after accepting 0xA5 → the sampled byte is still 0xA5.
- **Mid-byte reset:** assert `rst` low after the 3rd SCL rise → outputs at reset values immediately. After release, 0x11 transmits cleanly with no extra SCL edges.
